system_bus: RTL

//  Parametrised single-master system bus; successor to the fixed 8-bit CPU<->Memory wiring.

---
 rtl/system_bus.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/system_bus.sv
// ---------------------------------------------------------------------------
// system_bus
//
// Single-master system bus that connects the CPU to NUM_SLAVES memory-mapped
// slaves (RAM, ROM, I/O). The top SLV_W address bits select the slave. Every
// request gets exactly one completion: a one-cycle m_ready pulse, which m_err
// qualifies.
//
// Access flow:
//   IDLE   - wait for m_req. Latch we/addr/wdata and decode the slave index.
//            A mapped index goes to ACCESS. An unmapped index goes straight
//            to RESP with an error.
//   ACCESS - drive s_sel/s_we/s_addr/s_wdata to the selected slave and wait
//            for its s_ack. If TIMEOUT_CYCLES ACCESS cycles pass without an
//            ack, give up with an error. An ack in the final cycle still
//            counts as a normal completion.
//   RESP   - one cycle with m_ready=1. Always returns to IDLE.
//
// Error responses return all-ones read data and bump a saturating counter.
//
// Parameters:
//   DATA_W          data bus width
//   ADDR_W          address bus width (master and slave side are equal)
//   NUM_SLAVES      number of slaves behind the bus
//   TIMEOUT_CYCLES  ACCESS cycles allowed before a timeout error (>= 1)
//   ERRCNT_W        width of err_count
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   m_req      in   master request, held until m_ready
//   m_we       in   1 = write, 0 = read
//   m_addr     in   master address
//   m_wdata    in   master write data
//   m_rdata    out  read data, valid while m_ready=1
//   m_ready    out  one-cycle completion pulse
//   m_err      out  access failed (qualifies m_ready)
//   s_sel      out  one-hot slave select, only in ACCESS
//   s_we       out  write strobe to the selected slave
//   s_addr     out  full latched address
//   s_wdata    out  latched write data
//   s_rdata    in   flattened slave read data, slave i at [i*DATA_W +: DATA_W]
//   s_ack      in   per-slave completion, only the selected bit matters
//   err_count  out  saturating count of error responses
// ---------------------------------------------------------------------------
module system_bus #(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 8,
   parameter int NUM_SLAVES     = 2,
   parameter int TIMEOUT_CYCLES = 15,
   parameter int ERRCNT_W       = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         m_req,
   input  logic                         m_we,
   input  logic [ADDR_W-1:0]            m_addr,
   input  logic [DATA_W-1:0]            m_wdata,
   output logic [DATA_W-1:0]            m_rdata,
   output logic                         m_ready,
   output logic                         m_err,
   output logic [NUM_SLAVES-1:0]        s_sel,
   output logic                         s_we,
   output logic [ADDR_W-1:0]            s_addr,
   output logic [DATA_W-1:0]            s_wdata,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
   input  logic [NUM_SLAVES-1:0]        s_ack,
   output logic [ERRCNT_W-1:0]          err_count
);

   localparam int SLV_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic                 r_we;
   logic [ADDR_W-1:0]    r_addr;
   logic [DATA_W-1:0]    r_wdata;
   logic [SLV_W-1:0]     r_idx;
   logic [CNT_W-1:0]     r_wait_cnt;
   logic [DATA_W-1:0]    r_rdata;
   logic                 r_err;
   logic [ERRCNT_W-1:0]  r_err_count;

   logic [SLV_W-1:0]     w_req_idx;
   logic [31:0]          w_req_idx_ext;
   logic                 w_req_mapped;
   logic                 w_ack_sel;
   logic [DATA_W-1:0]    w_rdata_sel;
   logic                 w_timeout;

   // The counter holds at all-ones rather than wrapping back to zero.
   function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] val);
      if (val == {ERRCNT_W{1'b1}})
         return val;
      else
         return val + 1'b1;
   endfunction

   // Slave index decode. It is widened to 32 bits so the compare also works
   // when NUM_SLAVES is a power of two and cannot be written in SLV_W bits.
   assign w_req_idx     = m_addr[ADDR_W-1 -: SLV_W];
   assign w_req_idx_ext = 32'(w_req_idx);
   assign w_req_mapped  = (w_req_idx_ext < $unsigned(NUM_SLAVES));

   // Only the latched slave's ack and read data are visible. Acks from the
   // other slaves are ignored.
   always_comb begin
      w_ack_sel   = 1'b0;
      w_rdata_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_idx == SLV_W'(i)) begin
            w_ack_sel   = s_ack[i];
            w_rdata_sel = s_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_timeout = (r_wait_cnt == TO_LAST);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (m_req)
               w_state_nxt = w_req_mapped ? ST_ACCESS : ST_RESP;
         end
         ST_ACCESS: begin
            if (w_ack_sel || w_timeout)
               w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Request latch, response data, wait counter and error counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_idx       <= '0;
         r_wait_cnt  <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_err_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (m_req) begin
                  r_we       <= m_we;
                  r_addr     <= m_addr;
                  r_wdata    <= m_wdata;
                  r_idx      <= w_req_idx;
                  r_wait_cnt <= '0;
                  // Decode errors skip ACCESS, so the error response is set up here.
                  if (w_req_mapped) begin
                     r_err <= 1'b0;
                  end else begin
                     r_err   <= 1'b1;
                     r_rdata <= '1;
                  end
               end
            end
            ST_ACCESS: begin
               r_wait_cnt <= r_wait_cnt + 1'b1;
               // The ack is checked first, so an ack in the last allowed
               // cycle completes normally.
               if (w_ack_sel) begin
                  r_err   <= 1'b0;
                  r_rdata <= r_we ? '0 : w_rdata_sel;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= '1;
               end
            end
            ST_RESP: begin
               if (r_err)
                  r_err_count <= sat_inc(r_err_count);
            end
            default: begin
            end
         endcase
      end
   end

   // Output logic
   always_comb begin
      m_ready = 1'b0;
      m_err   = 1'b0;
      s_we    = 1'b0;
      s_sel   = '0;
      case (r_state)
         ST_ACCESS: begin
            s_we = r_we;
            for (int i = 0; i < NUM_SLAVES; i++)
               s_sel[i] = (r_idx == SLV_W'(i));
         end
         ST_RESP: begin
            m_ready = 1'b1;
            m_err   = r_err;
         end
         default: begin
         end
      endcase
   end

   assign m_rdata   = r_rdata;
   assign s_addr    = r_addr;
   assign s_wdata   = r_wdata;
   assign err_count = r_err_count;

endmodule
